// File: rtl/key_event_controller_pkg.sv
// Shared constants for the key event controller.
//   Register word addresses, debounce counter width, released key level,
//   and a helper that counts set bits in a key vector.
package key_event_controller_pkg;

  localparam int unsigned KEY_W     = 4;
  localparam int unsigned DB_CNT_W  = 16;
  localparam int unsigned PRESS_CNT_W = 8;

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_COUNT = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  localparam logic [KEY_W-1:0] KEYS_RELEASED = 4'hF;

  // Number of keys pressing in the same cycle, sized for the press counter.
  function automatic logic [PRESS_CNT_W-1:0] count_ones(input logic [KEY_W-1:0] v);
    logic [PRESS_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEY_W; i++) begin
      n = n + PRESS_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_event_controller_debounce.sv
// key_debounce: one push key.
//   clk, reset_n  : clock, async active-low reset
//   key_raw_n     : raw pin, active-low, asynchronous
//   level         : debounced level (1 = released)
//   press         : one-cycle pulse registered with the 1->0 debounced change
module key_debounce
  import key_event_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_n,
  output logic level,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LIMIT = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          sync_q, sync_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;

  // Synchronizer, stability counter and debounced level.
  always_comb begin
    sync_d  = {sync_q[0], key_raw_n};
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LIMIT) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {2{KEYS_RELEASED[0]}};
      cnt_q   <= '0;
      level_q <= KEYS_RELEASED[0];
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/key_event_controller.sv
// key_event_controller: debounced push keys with Avalon-MM register file.
//   clk, reset_n  : clock, async active-low reset
//   in_port       : raw key pins, active-low
//   address, chipselect, write_n, writedata : Avalon-MM slave write/select
//   readdata      : addressed register, registered (read latency 1)
//   irq           : OR(edgecapture & interruptmask), registered
module key_event_controller
  import key_event_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned NUM_KEYS        = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [KEY_W-1:0]  in_port,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic [KEY_W-1:0]       level;
  logic [KEY_W-1:0]       press;
  logic [KEY_W-1:0]       mask_q, mask_d;
  logic [KEY_W-1:0]       edge_q, edge_d;
  logic [PRESS_CNT_W-1:0] count_q, count_d;
  logic [31:0]            readdata_q, readdata_d;
  logic                   irq_q, irq_d;
  logic                   write_en;
  logic                   unused_wdata;

  assign unused_wdata = ^writedata[31:KEY_W];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_raw_n (in_port[i]),
      .level     (level[i]),
      .press     (press[i])
    );
  end

  assign write_en = chipselect & ~write_n;

  // Register file; a new press wins over a same-cycle clear.
  always_comb begin
    mask_d     = mask_q;
    edge_d     = edge_q;
    count_d    = count_q;
    readdata_d = '0;
    irq_d      = |(edge_q & mask_q);

    if (write_en && address == ADDR_MASK) mask_d = writedata[KEY_W-1:0];
    if (write_en && address == ADDR_EDGE) edge_d = edge_q & ~writedata[KEY_W-1:0];
    edge_d = edge_d | press;

    if (write_en && address == ADDR_COUNT) count_d = '0;
    count_d = count_d + count_ones(press);

    case (address)
      ADDR_LEVEL: readdata_d = 32'(level);
      ADDR_COUNT: readdata_d = 32'(count_q);
      ADDR_MASK:  readdata_d = 32'(mask_q);
      default:    readdata_d = 32'(edge_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      count_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
